hex_token_parser: RTL and testbench
===================================

HEX_TOKEN_PARSER -- requirements
Module: hex_token_parser

Interface
REQ-001 SHALL have parameter: MAX_DIGITS, 8, maximum hex digits per token (1..8).
REQ-002 SHALL derive value width VW = 4*MAX_DIGITS internally; not overridable.
REQ-003 SHALL have port: CLK  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port: RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: iDATA  input  8  ASCII byte from UART Rx.
REQ-006 SHALL have port: iVALID  input  1  iDATA valid.
REQ-007 SHALL have port: oREADY  output  1  parser accepts byte this cycle.
REQ-008 SHALL have port: oVALUE  output  VW  parsed token value, right-aligned, zero-extended.
REQ-009 SHALL have port: oDIGITS  output  4  digit count of oVALUE token (1..MAX_DIGITS).
REQ-010 SHALL have port: oVALID  output  1  oVALUE/oDIGITS valid.
REQ-011 SHALL have port: iREADY  input  1  consumer accepts token.
REQ-012 SHALL have port: oERROR  output  1  one-cycle pulse on malformed token.

Function
REQ-013 Byte SHALL be accepted only when iVALID && oREADY; token handed off only when oVALID && iREADY.
REQ-014 Hex digit = '0'-'9' (value 0-9), 'A'-'F' or 'a'-'f' (value 10-15); delimiter = 0x20, 0x09, 0x0D, 0x0A, 0x2C; all other bytes illegal.
REQ-015 FSM SHALL have states IDLE, ACCUM, HOLD, SKIP; oREADY = 1 in IDLE/ACCUM/SKIP, 0 in HOLD (decoded from state register).
REQ-016 IDLE: digit -> acc = nibble, cnt = 1, ACCUM; delimiter -> stay IDLE, no output (leading/repeated delimiters ignored); illegal -> oERROR, SKIP.
REQ-017 ACCUM: digit with cnt < MAX_DIGITS -> acc = {acc[VW-5:0], nibble}, cnt+1; digit with cnt == MAX_DIGITS -> oERROR (overflow), SKIP; delimiter -> oVALUE = acc, oDIGITS = cnt, oVALID = 1, HOLD; illegal -> oERROR, SKIP.
REQ-018 HOLD: oVALID, oVALUE, oDIGITS SHALL remain stable until iREADY = 1; on handoff cycle oVALID deasserts next cycle and FSM returns to IDLE.
REQ-019 SKIP: all bytes accepted and discarded; delimiter -> IDLE; no further oERROR pulses until next token.
REQ-020 Latency: delimiter accepted in cycle N SHALL give oVALID = 1 in cycle N+1; oERROR SHALL pulse exactly one cycle, in cycle N+1 after offending byte.
REQ-021 oVALUE SHALL keep last value after handoff; only updated on next token completion.
REQ-022 Delimiter terminating a token SHALL be consumed; it SHALL NOT start a new token.

Reset
REQ-023 RST_N low SHALL asynchronously force state = IDLE, acc = 0, cnt = 0, oVALUE = 0, oDIGITS = 0, oVALID = 0, oERROR = 0; oREADY = 1 by IDLE decode.
REQ-024 Reset mid-token or in HOLD SHALL discard the partial/pending token without oERROR.

Structure
REQ-025 Shared include file SHALL hold delimiter byte constants, FSM state encodings and digit-count width.
REQ-026 SHALL instantiate one combinational sub-module hex_nibble_decode: inputs 8-bit char; outputs is_hex, is_delim, nibble[3:0].
REQ-027 Total RTL SHALL target 120-400 lines; no memories; single clock domain.

Verification
REQ-028 Bytes "1A3f\r" back-to-back -> oVALID cycle after CR, oVALUE = 0x00001A3F, oDIGITS = 4, no oERROR.
REQ-029 "123456789 " (MAX_DIGITS=8) -> oERROR pulse after 9th digit, no oVALID; then "5\n" -> oVALUE = 0x00000005, oDIGITS = 1.
REQ-030 "12G4 7," -> oERROR once after 'G', "4 " discarded, then oVALUE = 0x00000007.
REQ-031 "FF," with iREADY low 5 cycles -> oVALID held high, oVALUE = 0x000000FF stable, oREADY = 0, iVALID bytes not consumed; iREADY high -> handoff, oREADY = 1 next cycle.
REQ-032 "  ,\r\n" only -> no oVALID, no oERROR, oREADY constantly 1.
REQ-033 "AB" then RST_N low 2 cycles -> all outputs 0, no oERROR; then "C " -> oVALUE = 0x0000000C, oDIGITS = 1.

Source files
------------

// File: rtl/hex_token_parser_pkg.sv
// Shared constants for the hex token parser: delimiter bytes, FSM state
// encodings and the digit-count width.
package hex_token_parser_pkg;

    localparam logic [7:0] DELIM_SPACE = 8'h20;
    localparam logic [7:0] DELIM_TAB   = 8'h09;
    localparam logic [7:0] DELIM_CR    = 8'h0D;
    localparam logic [7:0] DELIM_LF    = 8'h0A;
    localparam logic [7:0] DELIM_COMMA = 8'h2C;

    // Digit counter width; wide enough to hold MAX_DIGITS up to 8.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2,
        SKIP  = 2'd3
    } state_t;

endpackage

// File: rtl/hex_nibble_decode.sv
// Combinational ASCII classifier: flags hex digits and delimiters and
// returns the 4-bit value of a hex digit (zero for anything else).
module hex_nibble_decode
    import hex_token_parser_pkg::*;
(
    input  logic [7:0] char_byte,
    output logic       is_hex,
    output logic       is_delim,
    output logic [3:0] nibble
);

    // Classify the byte and convert hex digits to their value.
    always_comb begin
        is_hex   = 1'b0;
        nibble   = 4'h0;
        is_delim = char_byte inside {DELIM_SPACE, DELIM_TAB, DELIM_CR,
                                     DELIM_LF, DELIM_COMMA};
        if (char_byte >= 8'h30 && char_byte <= 8'h39) begin
            is_hex = 1'b1;
            nibble = 4'(char_byte - 8'h30);
        end else if (char_byte >= 8'h41 && char_byte <= 8'h46) begin
            is_hex = 1'b1;
            nibble = 4'(char_byte - 8'h37);
        end else if (char_byte >= 8'h61 && char_byte <= 8'h66) begin
            is_hex = 1'b1;
            nibble = 4'(char_byte - 8'h57);
        end
    end

endmodule

// File: rtl/hex_token_parser.sv
// Streaming parser that turns delimiter-separated ASCII hex tokens into
// right-aligned binary values with a valid/ready handoff and an error pulse
// for malformed or oversized tokens.
module hex_token_parser
    import hex_token_parser_pkg::*;
#(
    parameter int MAX_DIGITS = 8
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [7:0]              iDATA,
    input  logic                    iVALID,
    output logic                    oREADY,
    output logic [4*MAX_DIGITS-1:0] oVALUE,
    output logic [CNT_W-1:0]        oDIGITS,
    output logic                    oVALID,
    input  logic                    iREADY,
    output logic                    oERROR
);

    localparam int VW = 4 * MAX_DIGITS;

    state_t           state;
    logic [VW-1:0]    acc;
    logic [CNT_W-1:0] cnt;

    logic             is_hex;
    logic             is_delim;
    logic [3:0]       nibble;
    logic             accept;
    logic [VW-1:0]    acc_shift;

    hex_nibble_decode u_decode (
        .char_byte (iDATA),
        .is_hex    (is_hex),
        .is_delim  (is_delim),
        .nibble    (nibble)
    );

    // Bytes are only taken while no token is waiting for the consumer.
    assign oREADY    = (state != HOLD);
    assign accept    = iVALID && oREADY;
    assign acc_shift = (acc << 4) | VW'(nibble);

    // Token FSM with registered outputs; oERROR defaults low so it pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            oVALUE  <= '0;
            oDIGITS <= '0;
            oVALID  <= 1'b0;
            oERROR  <= 1'b0;
        end else begin
            oERROR <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_hex) begin
                            acc   <= VW'(nibble);
                            cnt   <= CNT_W'(1);
                            state <= ACCUM;
                        end else if (!is_delim) begin
                            oERROR <= 1'b1;
                            state  <= SKIP;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (is_hex) begin
                            if (cnt < CNT_W'(MAX_DIGITS)) begin
                                acc <= acc_shift;
                                cnt <= cnt + CNT_W'(1);
                            end else begin
                                // Too many digits for the value width.
                                oERROR <= 1'b1;
                                state  <= SKIP;
                            end
                        end else if (is_delim) begin
                            oVALUE  <= acc;
                            oDIGITS <= cnt;
                            oVALID  <= 1'b1;
                            state   <= HOLD;
                        end else begin
                            oERROR <= 1'b1;
                            state  <= SKIP;
                        end
                    end
                end
                HOLD: begin
                    // oVALUE/oDIGITS stay put after handoff until the next token.
                    if (iREADY) begin
                        oVALID <= 1'b0;
                        state  <= IDLE;
                    end
                end
                SKIP: begin
                    if (accept && is_delim) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_token_parser.sv
// Directed bench for hex_token_parser: a table of byte-per-cycle vectors with
// expected outputs, plus hand sequences for backpressure and reset.
module tb_hex_token_parser;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  iDATA = 8'h00;
    logic        iVALID = 1'b0;
    logic        iREADY = 1'b0;
    logic        oREADY;
    logic [31:0] oVALUE;
    logic [3:0]  oDIGITS;
    logic        oVALID;
    logic        oERROR;

    int checks = 0;
    int fails  = 0;

    hex_token_parser #(.MAX_DIGITS(8)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .iDATA   (iDATA),
        .iVALID  (iVALID),
        .oREADY  (oREADY),
        .oVALUE  (oVALUE),
        .oDIGITS (oDIGITS),
        .oVALID  (oVALID),
        .iREADY  (iREADY),
        .oERROR  (oERROR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        r;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_value;
        logic [3:0]  e_digits;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic v, input logic [7:0] d, input logic r,
                       input logic er, input logic ev, input logic [31:0] val,
                       input logic [3:0] dg, input logic ee);
        vec_t t;
        t.v = v; t.d = d; t.r = r;
        t.e_ready = er; t.e_valid = ev; t.e_value = val;
        t.e_digits = dg; t.e_err = ee;
        vq.push_back(t);
    endtask

    // Drive one cycle's inputs at the falling edge, sample just after the rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        @(negedge CLK);
        iVALID = v;
        iDATA  = d;
        iREADY = r;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic er, input logic ev,
                         input logic [31:0] val, input logic [3:0] dg, input logic ee);
        logic [38:0] act;
        logic [38:0] exp;
        act = {oREADY, oVALID, oVALUE, oDIGITS, oERROR};
        exp = {er, ev, val, dg, ee};
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got ready=%0b valid=%0b value=%h digits=%0d err=%0b, want ready=%0b valid=%0b value=%h digits=%0d err=%0b",
                     name, oREADY, oVALID, oVALUE, oDIGITS, oERROR, er, ev, val, dg, ee);
        end
    endtask

    initial begin
        // "1A3f\r" with an idle cycle in the middle
        add(1, "1", 1, 1, 0, 32'h0, 0, 0);
        add(1, "A", 1, 1, 0, 32'h0, 0, 0);
        add(0, "Z", 1, 1, 0, 32'h0, 0, 0);
        add(1, "3", 1, 1, 0, 32'h0, 0, 0);
        add(1, "f", 1, 1, 0, 32'h0, 0, 0);
        add(1, 8'h0D, 1, 0, 1, 32'h1A3F, 4, 0);
        add(0, 8'h00, 1, 1, 0, 32'h1A3F, 4, 0);
        // "123456789 " overflows, then "5\n"
        for (int i = 1; i <= 8; i++) add(1, 8'(8'h30 + i), 1, 1, 0, 32'h1A3F, 4, 0);
        add(1, "9", 1, 1, 0, 32'h1A3F, 4, 1);
        add(1, " ", 1, 1, 0, 32'h1A3F, 4, 0);
        add(1, "5", 1, 1, 0, 32'h1A3F, 4, 0);
        add(1, 8'h0A, 1, 0, 1, 32'h5, 1, 0);
        add(0, 8'h00, 1, 1, 0, 32'h5, 1, 0);
        // "12G4 7,"
        add(1, "1", 1, 1, 0, 32'h5, 1, 0);
        add(1, "2", 1, 1, 0, 32'h5, 1, 0);
        add(1, "G", 1, 1, 0, 32'h5, 1, 1);
        add(1, "4", 1, 1, 0, 32'h5, 1, 0);
        add(1, " ", 1, 1, 0, 32'h5, 1, 0);
        add(1, "7", 1, 1, 0, 32'h5, 1, 0);
        add(1, ",", 1, 0, 1, 32'h7, 1, 0);
        add(0, 8'h00, 1, 1, 0, 32'h7, 1, 0);
        // delimiters only
        add(1, " ", 1, 1, 0, 32'h7, 1, 0);
        add(1, " ", 1, 1, 0, 32'h7, 1, 0);
        add(1, ",", 1, 1, 0, 32'h7, 1, 0);
        add(1, 8'h0D, 1, 1, 0, 32'h7, 1, 0);
        add(1, 8'h0A, 1, 1, 0, 32'h7, 1, 0);
        // digit range edges and tab delimiter: "0a9F\t"
        add(1, "0", 1, 1, 0, 32'h7, 1, 0);
        add(1, "a", 1, 1, 0, 32'h7, 1, 0);
        add(1, "9", 1, 1, 0, 32'h7, 1, 0);
        add(1, "F", 1, 1, 0, 32'h7, 1, 0);
        add(1, 8'h09, 1, 0, 1, 32'h0A9F, 4, 0);
        add(0, 8'h00, 1, 1, 0, 32'h0A9F, 4, 0);
        // illegal in IDLE, second illegal byte in SKIP gives no new pulse
        add(1, "g", 1, 1, 0, 32'h0A9F, 4, 1);
        add(1, "z", 1, 1, 0, 32'h0A9F, 4, 0);
        add(1, ",", 1, 1, 0, 32'h0A9F, 4, 0);
        // exactly MAX_DIGITS digits, mixed case
        add(1, "D", 1, 1, 0, 32'h0A9F, 4, 0);
        add(1, "E", 1, 1, 0, 32'h0A9F, 4, 0);
        add(1, "A", 1, 1, 0, 32'h0A9F, 4, 0);
        add(1, "D", 1, 1, 0, 32'h0A9F, 4, 0);
        add(1, "b", 1, 1, 0, 32'h0A9F, 4, 0);
        add(1, "e", 1, 1, 0, 32'h0A9F, 4, 0);
        add(1, "e", 1, 1, 0, 32'h0A9F, 4, 0);
        add(1, "f", 1, 1, 0, 32'h0A9F, 4, 0);
        add(1, " ", 1, 0, 1, 32'hDEADBEEF, 8, 0);
        add(0, 8'h00, 1, 1, 0, 32'hDEADBEEF, 8, 0);
        // neighbours of the digit ranges are illegal
        add(1, "/", 1, 1, 0, 32'hDEADBEEF, 8, 1);
        add(1, " ", 1, 1, 0, 32'hDEADBEEF, 8, 0);
        add(1, "1", 1, 1, 0, 32'hDEADBEEF, 8, 0);
        add(1, ":", 1, 1, 0, 32'hDEADBEEF, 8, 1);
        add(1, 8'h0A, 1, 1, 0, 32'hDEADBEEF, 8, 0);
        add(1, "@", 1, 1, 0, 32'hDEADBEEF, 8, 1);
        add(1, ",", 1, 1, 0, 32'hDEADBEEF, 8, 0);

        // Asynchronous reset state
        #1;
        check("reset", 1, 0, 32'h0, 0, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].v, vq[i].d, vq[i].r);
            check($sformatf("row%0d", i), vq[i].e_ready, vq[i].e_valid,
                  vq[i].e_value, vq[i].e_digits, vq[i].e_err);
        end

        // Backpressure: "FF," held while the consumer stalls for 5 cycles
        step(1, "F", 0);
        step(1, "F", 0);
        step(1, ",", 0);
        check("hold_enter", 0, 1, 32'hFF, 2, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, "3", 0);
            check($sformatf("hold_stall%0d", i), 0, 1, 32'hFF, 2, 0);
        end
        step(1, "3", 1);
        check("hold_handoff", 1, 0, 32'hFF, 2, 0);
        // a stalled '3' must not have been taken: a comma now is just a delimiter
        step(1, ",", 1);
        check("hold_no_consume", 1, 0, 32'hFF, 2, 0);

        // Reset in the middle of a token
        step(1, "A", 1);
        step(1, "B", 1);
        check("mid_tok", 1, 0, 32'hFF, 2, 0);
        @(negedge CLK);
        iVALID = 1'b0;
        RST_N  = 1'b0;
        #1;
        check("mid_rst_async", 1, 0, 32'h0, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        check("mid_rst_hold", 1, 0, 32'h0, 0, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        step(1, "C", 1);
        check("after_rst_c", 1, 0, 32'h0, 0, 0);
        step(1, " ", 1);
        check("after_rst_tok", 0, 1, 32'hC, 1, 0);
        step(0, 8'h00, 1);
        check("after_rst_hand", 1, 0, 32'hC, 1, 0);

        // Reset while a token is pending in HOLD
        step(1, "7", 0);
        step(1, ",", 0);
        check("hold_pending", 0, 1, 32'h7, 1, 0);
        @(negedge CLK);
        iVALID = 1'b0;
        RST_N  = 1'b0;
        #1;
        check("hold_rst", 1, 0, 32'h0, 0, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        step(1, " ", 1);
        check("hold_rst_delim", 1, 0, 32'h0, 0, 0);
        step(1, "3", 1);
        step(1, 8'h0A, 1);
        check("hold_rst_tok", 0, 1, 32'h3, 1, 0);
        step(0, 8'h00, 1);
        check("hold_rst_hand", 1, 0, 32'h3, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
